// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states, parity
// mode codes and an elaboration-time ceil(log2) helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Smallest r with 2**r >= v; used for counter and pointer widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head. Pointers wrap
// naturally; the occupancy counter is one bit wider so full != empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    level
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave level alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (PTR_W+1)'(1);
                2'b01:   level <= level - (PTR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Configurable UART transmitter fed from a small FIFO. Frames are
// start / DATA_BITS LSB-first / optional parity / STOP_BITS stop, each bit
// CLK_DIV cycles. Queued words go out back-to-back; i_BREAK is honoured only
// between frames and is followed by at least one idle bit time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         i_CLK,
    input  logic                         i_RSTn,
    input  logic [DATA_BITS-1:0]         i_WDATA,
    input  logic                         i_WVALID,
    output logic                         o_WREADY,
    input  logic                         i_BREAK,
    output logic                         o_UART_TXD,
    output logic                         o_BUSY,
    output logic [clog2(FIFO_DEPTH):0]   o_LEVEL
);

    localparam int BAUD_W = clog2(CLK_DIV);
    localparam int BIT_W  = clog2(DATA_BITS + 1);

    state_t                 state, state_nx;
    logic [BAUD_W-1:0]      baud, baud_nx;
    logic [BIT_W-1:0]       bitcnt, bitcnt_nx;
    logic [DATA_BITS-1:0]   shift, shift_nx;
    logic                   par, par_nx;
    logic                   txd, txd_nx;
    logic                   hold, hold_nx;
    logic                   load;
    logic                   at_bnd;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_CLK),
        .rst_n (i_RSTn),
        .push  (i_WVALID),
        .pop   (load),
        .wdata (i_WDATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_LEVEL)
    );

    assign o_WREADY   = !fifo_full;
    assign o_UART_TXD = txd;
    assign o_BUSY     = (state != S_IDLE) || !fifo_empty;
    assign at_bnd     = (baud == BAUD_W'(CLK_DIV - 1));

    // Frame sequencing: next state, next line level, and when to pop a word.
    // 'hold' keeps IDLE from starting a frame until a full high bit time has
    // elapsed after a break.
    always_comb begin
        state_nx  = state;
        baud_nx   = baud;
        bitcnt_nx = bitcnt;
        shift_nx  = shift;
        par_nx    = par;
        txd_nx    = txd;
        hold_nx   = hold;
        load      = 1'b0;

        if (state != S_IDLE && state != S_BREAK) begin
            baud_nx = at_bnd ? '0 : baud + BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                txd_nx  = 1'b1;
                baud_nx = '0;
                if (hold) begin
                    baud_nx = at_bnd ? '0 : baud + BAUD_W'(1);
                    hold_nx = !at_bnd;
                end
                if (i_BREAK) begin
                    state_nx = S_BREAK;
                    txd_nx   = 1'b0;
                    baud_nx  = '0;
                    hold_nx  = 1'b0;
                end else if (!fifo_empty && (!hold || at_bnd)) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (at_bnd) begin
                    state_nx  = S_DATA;
                    txd_nx    = shift[0];
                    shift_nx  = shift >> 1;
                    bitcnt_nx = '0;
                end
            end
            S_DATA: begin
                if (at_bnd) begin
                    if (bitcnt == BIT_W'(DATA_BITS - 1)) begin
                        bitcnt_nx = '0;
                        if (PARITY != PAR_NONE) begin
                            state_nx = S_PARITY;
                            txd_nx   = par;
                        end else begin
                            state_nx = S_STOP;
                            txd_nx   = 1'b1;
                        end
                    end else begin
                        bitcnt_nx = bitcnt + BIT_W'(1);
                        txd_nx    = shift[0];
                        shift_nx  = shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (at_bnd) begin
                    state_nx  = S_STOP;
                    txd_nx    = 1'b1;
                    bitcnt_nx = '0;
                end
            end
            S_STOP: begin
                if (at_bnd) begin
                    if (bitcnt == BIT_W'(STOP_BITS - 1)) begin
                        bitcnt_nx = '0;
                        if (!fifo_empty && !i_BREAK) begin
                            load = 1'b1;
                        end else begin
                            state_nx = S_IDLE;
                            txd_nx   = 1'b1;
                        end
                    end else begin
                        bitcnt_nx = bitcnt + BIT_W'(1);
                    end
                end
            end
            S_BREAK: begin
                txd_nx  = 1'b0;
                baud_nx = '0;
                if (!i_BREAK) begin
                    state_nx = S_IDLE;
                    txd_nx   = 1'b1;
                    hold_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                txd_nx   = 1'b1;
            end
        endcase

        // Popping the head always launches a start bit on the same edge.
        if (load) begin
            state_nx  = S_START;
            txd_nx    = 1'b0;
            baud_nx   = '0;
            bitcnt_nx = '0;
            shift_nx  = fifo_rdata;
            par_nx    = (^fifo_rdata) ^ (PARITY == PAR_ODD);
        end
    end

    // FSM and datapath registers; reset drives the line high immediately.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state  <= S_IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
            par    <= 1'b0;
            txd    <= 1'b1;
            hold   <= 1'b0;
        end else begin
            state  <= state_nx;
            baud   <= baud_nx;
            bitcnt <= bitcnt_nx;
            shift  <= shift_nx;
            par    <= par_nx;
            txd    <= txd_nx;
            hold   <= hold_nx;
        end
    end

endmodule
